// File: rtl/multdiv_sequencer.sv
// Control FSM that issues mul/div to the shared multi-cycle unit, stalls decode and arbitrates one write-back.
// Optional watchdog: define MULTDIV_WATCHDOG_EN to convert a BUSY timeout into an rstatus exception.
module multdiv_sequencer #(
    parameter int RSTATUS_REG    = 30,
    parameter int MUL_EXC_CODE   = 4,
    parameter int DIV_EXC_CODE   = 5,
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_opcode,
    input  logic [4:0]  issue_aluop,
    input  logic [4:0]  issue_rd,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        md_busy
);

    localparam logic [4:0]       RSTATUS_IDX = 5'(RSTATUS_REG);
    localparam logic [31:0]      MUL_CODE    = 32'(MUL_EXC_CODE);
    localparam logic [31:0]      DIV_CODE    = 32'(DIV_EXC_CODE);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_w_check
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_WB} state_t;

    state_t           state, state_nx;
    logic             kind_div;
    logic [4:0]       rd_q;
    logic [CNT_W-1:0] cnt;
    logic             is_md;
    logic             timeout;
    logic             finish;

    assign is_md = issue_valid && (issue_opcode == 5'd0) &&
                   ((issue_aluop == 5'd6) || (issue_aluop == 5'd7));

`ifdef MULTDIV_WATCHDOG_EN
    // Counter holds (BUSY cycles - 1), so this fires on the last allowed BUSY cycle.
    assign timeout = (state == S_BUSY) && !md_resultRDY &&
                     (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    assign finish = (state == S_BUSY) && (md_resultRDY || timeout);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (is_md) state_nx = S_START;
            S_START: state_nx = S_BUSY;
            S_BUSY: begin
                if (md_resultRDY) begin
                    // A clean result aimed at $r0 is dropped without a write-back.
                    state_nx = (md_exception || (rd_q != 5'd0)) ? S_WB : S_IDLE;
                end else if (timeout) begin
                    state_nx = S_WB;
                end
            end
            S_WB:    if (wb_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        wb_valid = (state == S_WB);
        md_busy  = (state != S_IDLE);
        stall    = (state != S_IDLE) || is_md;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            kind_div     <= 1'b0;
            rd_q         <= 5'd0;
            cnt          <= '0;
            md_ctrl_mult <= 1'b0;
            md_ctrl_div  <= 1'b0;
            wb_reg       <= 5'd0;
            wb_data      <= 32'd0;
        end else begin
            md_ctrl_mult <= (state == S_IDLE) && is_md && !issue_aluop[0];
            md_ctrl_div  <= (state == S_IDLE) && is_md &&  issue_aluop[0];

            if ((state == S_IDLE) && is_md) begin
                kind_div <= issue_aluop[0];
                rd_q     <= issue_rd;
            end

            if (state == S_START) begin
                cnt <= '0;
            end else if ((state == S_BUSY) && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end

            if (finish) begin
                if (timeout || md_exception) begin
                    wb_reg  <= RSTATUS_IDX;
                    wb_data <= kind_div ? DIV_CODE : MUL_CODE;
                end else if (rd_q != 5'd0) begin
                    wb_reg  <= rd_q;
                    wb_data <= md_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomized self-checking bench for multdiv_sequencer against a cycle-offset transaction model.
// Build with MULTDIV_WATCHDOG_EN defined to also exercise the watchdog path.
module tb_multdiv_sequencer;

    localparam int TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_opcode = '0;
    logic [4:0]  issue_aluop = '0;
    logic [4:0]  issue_rd = '0;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_result = '0;
    logic        md_exception = 1'b0;
    logic        md_resultRDY = 1'b0;
    logic        stall;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        md_busy;

    int errs = 0;
    int checks = 0;

    multdiv_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_opcode (issue_opcode),
        .issue_aluop  (issue_aluop),
        .issue_rd     (issue_rd),
        .md_ctrl_mult (md_ctrl_mult),
        .md_ctrl_div  (md_ctrl_div),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_resultRDY (md_resultRDY),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .md_busy      (md_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_md_ref(input logic v, input logic [4:0] op, input logic [4:0] alu);
        return v && (op == 5'd0) && (alu == 5'd6 || alu == 5'd7);
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Idle cycles with random non-md instructions and noise on the unit/regfile inputs.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            issue_valid  = 1'($urandom);
            issue_opcode = ($urandom % 2) ? 5'd0 : 5'($urandom);
            issue_aluop  = 5'($urandom);
            if (is_md_ref(issue_valid, issue_opcode, issue_aluop)) issue_aluop = 5'd8;
            issue_rd     = 5'($urandom);
            md_resultRDY = 1'($urandom);
            md_exception = 1'($urandom);
            md_result    = $urandom;
            wb_ready     = 1'($urandom);
            @(negedge clock);
            chk("idle_stall", 32'(stall), 32'd0);
            chk("idle_busy", 32'(md_busy), 32'd0);
            chk("idle_wb_valid", 32'(wb_valid), 32'd0);
            chk("idle_ctrl", 32'({md_ctrl_mult, md_ctrl_div}), 32'd0);
            next_cycle();
        end
    endtask

    // One operation; cycle 0 is the issue cycle, START is cycle 1, RDY lands lat cycles after START.
    task automatic run_op(input bit is_div, input logic [4:0] rd, input int lat, input bit exc,
                          input bit no_rdy, input logic [31:0] res, input int rdly, input bit rdy_in_start);
        bit          writes;
        int          end_cyc;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        bit          exp_wbv;
        writes   = exc || (rd != 5'd0);
        end_cyc  = writes ? (2 + lat + rdly) : (1 + lat);
        exp_reg  = exc ? 5'd30 : rd;
        exp_data = exc ? (is_div ? 32'd5 : 32'd4) : res;
        for (int cyc = 0; cyc <= end_cyc + 1; cyc++) begin
            issue_valid  = (cyc == 0);
            issue_opcode = (cyc == 0) ? 5'd0 : 5'($urandom);
            issue_aluop  = (cyc == 0) ? (is_div ? 5'd7 : 5'd6) : 5'($urandom);
            issue_rd     = (cyc == 0) ? rd : 5'($urandom);
            if (cyc == 1 + lat && !no_rdy) begin
                md_resultRDY = 1'b1;
                md_exception = exc;
                md_result    = res;
            end else begin
                md_resultRDY = (cyc == 1 && rdy_in_start) || (cyc >= 2 + lat && 1'($urandom));
                md_exception = 1'($urandom);
                md_result    = $urandom;
            end
            wb_ready = (cyc >= 2 + lat) ? (cyc == 2 + lat + rdly) : 1'($urandom);
            @(negedge clock);
            exp_wbv = writes && (cyc >= 2 + lat) && (cyc <= end_cyc);
            chk("ctrl_mult", 32'(md_ctrl_mult), 32'(cyc == 1 && !is_div));
            chk("ctrl_div", 32'(md_ctrl_div), 32'(cyc == 1 && is_div));
            chk("busy", 32'(md_busy), 32'(cyc >= 1 && cyc <= end_cyc));
            chk("stall", 32'(stall), 32'(cyc <= end_cyc));
            chk("wb_valid", 32'(wb_valid), 32'(exp_wbv));
            if (exp_wbv) begin
                chk("wb_reg", 32'(wb_reg), 32'(exp_reg));
                chk("wb_data", wb_data, exp_data);
            end
            next_cycle();
        end
        issue_valid  = 1'b0;
        md_resultRDY = 1'b0;
        wb_ready     = 1'b0;
    endtask

    initial begin
        // Reset: everything registered must read zero.
        next_cycle();
        next_cycle();
        @(negedge clock);
        chk("rst_ctrl", 32'({md_ctrl_mult, md_ctrl_div}), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_reg", 32'(wb_reg), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        next_cycle();
        reset = 1'b1;
        idle_cycles(3);

        run_op(1'b0, 5'd5, 16, 1'b0, 1'b0, 32'h0000_0C8A, 0, 1'b0);
        run_op(1'b1, 5'd7, 6, 1'b1, 1'b0, 32'hDEAD_BEEF, 0, 1'b1);
        run_op(1'b0, 5'd7, 9, 1'b1, 1'b0, 32'h1234_5678, 1, 1'b0);
        run_op(1'b0, 5'd0, 5, 1'b0, 1'b0, 32'h5555_AAAA, 0, 1'b0);
        run_op(1'b1, 5'd0, 3, 1'b1, 1'b0, 32'h0, 2, 1'b0);
        run_op(1'b1, 5'd19, 1, 1'b0, 1'b0, 32'hCAFE_F00D, 3, 1'b0);
        idle_cycles(2);

        // Reset in BUSY, then a late RDY that must be ignored.
        issue_valid = 1'b1; issue_opcode = 5'd0; issue_aluop = 5'd6; issue_rd = 5'd9;
        next_cycle();
        issue_valid = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_busy", 32'(md_busy), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_wb_reg", 32'(wb_reg), 32'd0);
        chk("midrst_wb_data", wb_data, 32'd0);
        next_cycle();
        md_resultRDY = 1'b1; md_exception = 1'b1; md_result = 32'hFFFF_FFFF; wb_ready = 1'b1;
        next_cycle();
        md_resultRDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("late_rdy_wb_valid", 32'(wb_valid), 32'd0);
            chk("late_rdy_busy", 32'(md_busy), 32'd0);
            chk("late_rdy_stall", 32'(stall), 32'd0);
            next_cycle();
        end
        wb_ready = 1'b0;

        for (int n = 0; n < 30; n++) begin
            run_op(1'($urandom), ($urandom % 4 == 0) ? 5'd0 : 5'($urandom),
                   int'($urandom_range(1, 30)), ($urandom % 4 == 0), 1'b0, $urandom,
                   int'($urandom_range(0, 3)), 1'($urandom));
            idle_cycles(int'($urandom_range(0, 3)));
        end

`ifdef MULTDIV_WATCHDOG_EN
        run_op(1'b0, 5'd12, TIMEOUT, 1'b1, 1'b1, 32'h0, 0, 1'b0);
        run_op(1'b1, 5'd3, TIMEOUT, 1'b1, 1'b1, 32'h0, 2, 1'b0);
        md_resultRDY = 1'b1; md_exception = 1'b0; md_result = 32'h0BAD_0BAD;
        next_cycle();
        md_resultRDY = 1'b0;
        @(negedge clock);
        chk("wd_late_rdy_wb_valid", 32'(wb_valid), 32'd0);
        chk("wd_late_rdy_busy", 32'(md_busy), 32'd0);
        next_cycle();
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Control FSM that sequences the shared multi-cycle multiply/divide unit for R-type mul (opcode 00000, ALUop 00110) and div (opcode 00000, ALUop 00111).
- Sits between the decode stage and the register-file write port. Raises stall while an operation is in flight and pulses the unit's start controls.
- Waits for result-ready, then arbitrates one write-back: result to Rd, or an rstatus code to $r30 on exception.

Parameters:
- RSTATUS_REG, 30, register index written on exception.
- MUL_EXC_CODE, 4, rstatus value for a mul exception.
- DIV_EXC_CODE, 5, rstatus value for a div exception.
- TIMEOUT_CYCLES, 40, watchdog limit in BUSY cycles (used only with the optional feature).
- CNT_W, 6, cycle-counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- issue_valid  in  1  the decode stage holds a valid instruction.
- issue_opcode  in  5  instruction[31:27].
- issue_aluop  in  5  instruction[6:2].
- issue_rd  in  5  instruction[26:22].
- md_ctrl_mult  out  1  one-cycle start pulse, multiply.
- md_ctrl_div  out  1  one-cycle start pulse, divide.
- md_result  in  32  unit result.
- md_exception  in  1  overflow or divide-by-zero; valid with md_resultRDY.
- md_resultRDY  in  1  result valid, one-cycle pulse.
- stall  out  1  freezes fetch/decode; operand registers stay stable.
- wb_valid  out  1  write-back request to the regfile port.
- wb_ready  in  1  regfile port grant.
- wb_reg  out  5  write-back destination.
- wb_data  out  32  write-back data.
- md_busy  out  1  state != IDLE.

Behaviour:
- Reset (reset==0 at clock edge): state=IDLE, counter=0, all latches cleared. All registered outputs are 0: md_ctrl_*, wb_valid, wb_reg, wb_data, md_busy. Reset mid-operation abandons the op with no write-back; a late md_resultRDY after reset is ignored.
- is_md = issue_valid & (issue_opcode==0) & (issue_aluop==6 or 7).
- stall is combinational: stall = (state!=IDLE) | is_md. Decode freezes in the same cycle the op is seen.
- IDLE:
  - If is_md: latch kind (mul/div) and issue_rd, then go to START.
  - Otherwise stay in IDLE.
- START (exactly 1 cycle):
  - md_ctrl_mult or md_ctrl_div = 1 (registered, only the one matching the latched kind). Both are never high together.
  - md_resultRDY in this cycle is ignored.
  - Clear counter, go to BUSY.
- BUSY:
  - Counter increments each cycle and saturates at all-ones.
  - On md_resultRDY:
    - If md_exception: wb_reg=RSTATUS_REG, wb_data=zero-extended MUL_EXC_CODE or DIV_EXC_CODE; go to WB.
    - Else if latched rd==0: discard the result and go directly to IDLE with no write-back.
    - Else: wb_reg=rd, wb_data=md_result; go to WB.
- WB:
  - wb_valid=1. wb_reg and wb_data stay stable until the handshake.
  - Handshake = wb_valid & wb_ready at a clock edge. On handshake go to IDLE; wb_valid drops the next cycle.
  - wb_ready asserted in the same cycle wb_valid first rises completes in 1 cycle.
  - Holding wb_ready low holds WB indefinitely, with no timeout.
- Latency: if md_resultRDY arrives N cycles after START, wb_valid rises N+1 cycles after START; stall deasserts the cycle after the handshake.
- Back-to-back: a new is_md is accepted only in IDLE, so the earliest next START is 2 cycles after the handshake edge.
- Non-md instructions never affect the FSM.

Optional Feature:
- Macro MULTDIV_WATCHDOG_EN.
  - Defined: if BUSY lasts TIMEOUT_CYCLES cycles without md_resultRDY, treat it as an exception. Write the matching code to RSTATUS_REG through WB and ignore any later md_resultRDY for that op.
  - Undefined: no watchdog; BUSY waits forever; the counter is still present but unused for control.

Test Plan:
- mul, rd=5; RDY 16 cycles after START with result 0x0000_0C8A, no exception, wb_ready=1 -> single md_ctrl_mult pulse; wb_valid for 1 cycle with wb_reg=5, wb_data=0x0000_0C8A; stall high from issue until the cycle after the handshake.
- div, rd=7; RDY with exception=1 -> md_ctrl_div only; wb_reg=30, wb_data=5. Repeat for mul -> wb_data=4.
- mul, rd=0, no exception -> no wb_valid; return to IDLE the cycle after RDY.
- WB with wb_ready low for 3 cycles -> wb_valid, wb_reg and wb_data held stable for 4 cycles; handshake on the 4th.
- reset=0 asserted in BUSY, then RDY pulsed after release -> outputs 0, no write-back, stall=0 in IDLE.
- (MULTDIV_WATCHDOG_EN) mul, no RDY -> after 40 BUSY cycles wb_reg=30, wb_data=4; a late RDY is ignored.
